// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_e : control FSM states
//   digit_e : radix-4 Booth digit {0, +1, +2, -1, -2}
//   recode  : 3-bit multiplier window (m[2k+1], m[2k], m[2k-1]) -> digit
package booth_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   typedef enum logic [2:0] {DigZero, DigP1, DigP2, DigM1, DigM2} digit_e;

   function automatic digit_e recode(input logic [2:0] win);
      digit_e d;
      case (win)
         3'b001, 3'b010: d = DigP1;
         3'b011:         d = DigP2;
         3'b100:         d = DigM2;
         3'b101, 3'b110: d = DigM1;
         default:        d = DigZero;   // 000 and 111
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational radix-4 Booth recoder.
//   window : in  3 bits, multiplier bits (m[2k+1], m[2k], m[2k-1])
//   digit  : out Booth digit for that window
module booth_recoder
   import booth_pkg::*;
(
   input  logic [2:0] window,
   output digit_e     digit
);

   assign digit = recode(window);

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional approximate mode zeroes the low APPROX_BITS columns of every partial product.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : in  operand pair offered
//   in_ready      : out idle, operands accepted when in_valid is high
//   multiplier    : in  WIDTH, Booth-recoded operand
//   multiplicand  : in  WIDTH, operand scaled by the digits
//   is_signed     : in  1 = two's complement operands, 0 = unsigned
//   approx        : in  1 = approximate mode
//   out_valid     : out product available
//   out_ready     : in  consumer accepts product
//   product       : out 2*WIDTH registered result, holds the last result until replaced
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned APPROX_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic                 is_signed,
   input  logic                 approx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned EW   = WIDTH + 2;        // extended operand width
   localparam int unsigned AW   = 2 * WIDTH + 4;    // accumulator width
   localparam int unsigned NDIG = WIDTH / 2 + 1;    // Booth digits
   localparam int unsigned CW   = $clog2(NDIG);

   localparam logic [CW-1:0] LastDig = CW'(NDIG - 1);

   function automatic logic [AW-1:0] approx_mask();
      logic [AW-1:0] m;
      for (int unsigned i = 0; i < AW; i++) begin
         m[i] = (i >= APPROX_BITS);
      end
      return m;
   endfunction

   localparam logic [AW-1:0] ApproxMask = approx_mask();

   state_e              state_q, state_d;
   logic [EW:0]         mplier_q, mplier_d;   // {m_ext, m[-1]}, shifted right 2 per digit
   logic [AW-1:0]       mcand_q, mcand_d;     // multiplicand_ext * 4^k
   logic [AW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                approx_q, approx_d;
   logic [2*WIDTH-1:0]  product_q, product_d;

   logic                accept;
   logic                mr_sx, md_sx;
   digit_e              digit;
   logic [AW-1:0]       mcand_x2, term, term_m, acc_sum;

   booth_recoder u_recoder (
      .window (mplier_q[2:0]),
      .digit  (digit)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid)         state_d = StRun;
         StRun:   if (cnt_q == LastDig) state_d = StDone;
         StDone:  if (out_ready)        state_d = StIdle;
         default:                       state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from registered state only
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   assign accept  = in_valid & in_ready;
   assign mr_sx   = is_signed & multiplier[WIDTH-1];
   assign md_sx   = is_signed & multiplicand[WIDTH-1];
   assign product = product_q;

   // Partial product; the mask is applied after negation so the +1 is truncated too
   always_comb begin
      mcand_x2 = mcand_q << 1;
      term     = '0;
      unique case (digit)
         DigZero: term = '0;
         DigP1:   term = mcand_q;
         DigP2:   term = mcand_x2;
         DigM1:   term = -mcand_q;
         DigM2:   term = -mcand_x2;
         default: term = '0;
      endcase
      term_m  = approx_q ? (term & ApproxMask) : term;
      acc_sum = acc_q + term_m;
   end

   always_comb begin
      mplier_d  = mplier_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      approx_d  = approx_q;
      product_d = product_q;
      if (accept) begin
         mplier_d = {{2{mr_sx}}, multiplier, 1'b0};
         mcand_d  = {{(AW - WIDTH){md_sx}}, multiplicand};
         acc_d    = '0;
         cnt_d    = '0;
         approx_d = approx;
      end else if (state_q == StRun) begin
         mplier_d = mplier_q >> 2;
         mcand_d  = mcand_q << 2;
         acc_d    = acc_sum;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LastDig) product_d = acc_sum[2*WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mplier_q  <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         approx_q  <= 1'b0;
         product_q <= '0;
      end else begin
         mplier_q  <= mplier_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         approx_q  <= approx_d;
         product_q <= product_d;
      end
   end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult (WIDTH=16, APPROX_BITS=8).
module tb_booth_seq_mult;

   localparam int unsigned W = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    multiplier = '0;
   logic [W-1:0]    multiplicand = '0;
   logic            is_signed = 1'b0;
   logic            approx = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2*W-1:0]  product;

   int n_checks = 0;
   int n_fail   = 0;

   booth_seq_mult #(
      .WIDTH       (W),
      .APPROX_BITS (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .is_signed    (is_signed),
      .approx       (approx),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer operands for one cycle, then scramble inputs to show they are ignored
   task automatic start_op(input logic [W-1:0] mr, input logic [W-1:0] md,
                           input logic sgn, input logic apx);
      @(negedge clk);
      in_valid     = 1'b1;
      multiplier   = mr;
      multiplicand = md;
      is_signed    = sgn;
      approx       = apx;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      multiplier   = '1;
      multiplicand = '1;
      is_signed    = ~sgn;
      approx       = ~apx;
   endtask

   // Cycles from the accept edge to out_valid, bounded
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handoff();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] md,
                         input logic sgn, input logic apx,
                         output logic [2*W-1:0] res, output int lat);
      start_op(mr, md, sgn, apx);
      wait_done(lat);
      res = product;
      handoff();
   endtask

   initial begin
      logic [2*W-1:0] res;
      int             lat;
      int             seen;

      // Asynchronous reset, observed before any clock edge
      #2 rst = 1'b1;
      #1;
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_product", 64'(product), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Exact unsigned, latency
      run_op(16'd62, 16'd65, 1'b0, 1'b0, res, lat);
      check_eq("exact_62x65", 64'(res), 64'd4030);
      check_eq("latency", 64'(lat), 64'd9);

      // Sweep i * (i+3)
      for (int i = 0; i <= 62; i++) begin
         run_op(W'(i), W'(i + 3), 1'b0, 1'b0, res, lat);
         check_eq($sformatf("sweep_%0d", i), 64'(res), 64'(i * (i + 3)));
      end

      // Signed / unsigned
      run_op(16'hFFFD, 16'd7, 1'b1, 1'b0, res, lat);
      check_eq("signed_m3x7", 64'(res), 64'hFFFF_FFEB);
      run_op(16'hFFFD, 16'd7, 1'b0, 1'b0, res, lat);
      check_eq("unsigned_fffdx7", 64'(res), 64'h0006_FFEB);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, res, lat);
      check_eq("unsigned_ffffsq", 64'(res), 64'hFFFE_0001);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, res, lat);
      check_eq("signed_m1sq", 64'(res), 64'h0000_0001);

      // Approximate mode
      run_op(16'h0100, 16'h0003, 1'b0, 1'b1, res, lat);
      check_eq("approx_100x3", 64'(res), 64'd768);
      run_op(16'd8, 16'd5, 1'b0, 1'b1, res, lat);
      check_eq("approx_8x5", 64'(res), 64'hFFFF_FF00);
      check_eq("approx_latency", 64'(lat), 64'd9);
      run_op(16'd8, 16'd5, 1'b0, 1'b0, res, lat);
      check_eq("exact_8x5", 64'(res), 64'd40);

      // Backpressure: hold the result, ignore a new offer
      start_op(16'd62, 16'd65, 1'b0, 1'b0);
      wait_done(lat);
      check_eq("bp_latency", 64'(lat), 64'd9);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid     = (c == 1 || c == 2);
         multiplier   = 16'd3;
         multiplicand = 16'd3;
         is_signed    = 1'b0;
         approx       = 1'b0;
         @(posedge clk);
         #1;
         check_eq($sformatf("bp_product_%0d", c), 64'(product), 64'd4030);
         check_eq($sformatf("bp_out_valid_%0d", c), 64'(out_valid), 64'd1);
         check_eq($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      multiplier   = 16'd10;
      multiplicand = 16'd11;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("bp_idle_in_ready", 64'(in_ready), 64'd1);
      check_eq("bp_idle_out_valid", 64'(out_valid), 64'd0);
      check_eq("bp_idle_product", 64'(product), 64'd4030);
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("bp_next_accepted", 64'(in_ready), 64'd0);
      wait_done(lat);
      check_eq("bp_next_latency", 64'(lat), 64'd9);
      check_eq("bp_next_product", 64'(product), 64'd110);
      handoff();

      // Reset in the middle of RUN, at digit 4
      start_op(16'd200, 16'd300, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_product", 64'(product), 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq("midrst_no_valid", 64'(seen), 64'd0);
      check_eq("midrst_idle", 64'(in_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
